// File: rtl/q_to_w_serializer.sv
// q_to_w_serializer: 16-bit word FIFO drained as two bytes, high byte first.
// W/WV are registered (no fall-through): a word pushed into an empty FIFO
// shows its high byte right after the accepting edge.
// Optional build macro QTW_PARITY_EN adds WP, registered odd parity over W.
module q_to_w_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [15:0]              Q,
  input  logic                     QV,
  output logic                     QR,
  output logic [7:0]               W,
  output logic                     WV,
  input  logic                     WR,
  output logic [$clog2(DEPTH):0]   COUNT
`ifdef QTW_PARITY_EN
  ,
  output logic                     WP
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_HI = 2'd1, S_LO = 2'd2} state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, remain;
  state_t        state_q, state_d;
  logic [7:0]    w_q, w_d;
  logic          wv_q, wv_d;
  logic [15:0]   head_d;
  logic          push, xfer, pop;

  // Handshake decode: ready comes from registered occupancy only, so a full
  // FIFO never takes a word on the same edge it pops one.
  assign QR     = (count_q != CW'(DEPTH));
  assign push   = QV & QR;
  assign xfer   = wv_q & WR;
  assign pop    = xfer & (state_q == S_LO);
  assign remain = count_q - CW'(pop);

  // Next pointers/occupancy and the word that will be at the head after this edge.
  // If nothing older survives the pop, the head is the incoming word itself.
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    head_d  = (remain == '0) ? Q : mem[rptr_d];
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr_q] <= Q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  // FSM next state: EMPTY -> HI on first word, HI -> LO on a byte, LO -> HI/EMPTY on pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push) state_d = S_HI;
      S_HI:    if (xfer) state_d = S_LO;
      S_LO:    if (xfer) state_d = (count_d != '0) ? S_HI : S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM outputs, computed for the next state so W/WV can be registered.
  // Staying in HI or LO re-selects the same head byte, which keeps W stable on stalls.
  always_comb begin
    w_d  = 8'h00;
    wv_d = 1'b0;
    case (state_d)
      S_HI: begin w_d = head_d[15:8]; wv_d = 1'b1; end
      S_LO: begin w_d = head_d[7:0];  wv_d = 1'b1; end
      default: begin w_d = 8'h00; wv_d = 1'b0; end
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      w_q  <= 8'h00;
      wv_q <= 1'b0;
    end else begin
      w_q  <= w_d;
      wv_q <= wv_d;
    end
  end

  assign W     = w_q;
  assign WV    = wv_q;
  assign COUNT = count_q;

`ifdef QTW_PARITY_EN
  logic wp_q;
  // Odd parity registered alongside W: W plus WP always has an odd number of ones.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) wp_q <= 1'b1;
    else         wp_q <= ~^w_d;
  end
  assign WP = wp_q;
`endif

endmodule

// File: tb/tb_q_to_w_serializer.sv
// Scoreboard bench for q_to_w_serializer: the driver queues expected bytes on
// every accepted word; a negedge monitor checks bytes, occupancy and handshakes.
module tb_q_to_w_serializer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic [15:0]   Q;
  logic          QV, QR, WV, WR;
  logic [7:0]    W;
  logic [CW-1:0] COUNT;
`ifdef QTW_PARITY_EN
  logic          WP;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] expq [$];

  q_to_w_serializer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESETN(RESETN), .Q(Q), .QV(QV), .QR(QR),
    .W(W), .WV(WV), .WR(WR), .COUNT(COUNT)
`ifdef QTW_PARITY_EN
    , .WP(WP)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive, note acceptance just before the edge, step past it.
  task automatic cyc(input logic qv, input logic [15:0] q, input logic wr);
    QV = qv; Q = q; WR = wr;
    @(negedge CLK);
    if (RESETN && QV && QR) begin
      expq.push_back(q[15:8]);
      expq.push_back(q[7:0]);
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n, input logic wr);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom), wr);
  endtask

  // Monitor: model occupancy = words accepted - words fully sent; bytes alternate hi/lo.
  int         mcnt = 0;
  bit         phase = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_w = 8'h00;
  always @(negedge CLK) begin
    logic [7:0] e;
    bit acc, popw;
    if (!RESETN) begin
      mcnt = 0; phase = 0; prev_stall = 0;
    end else begin
      chk("count", 32'(COUNT), 32'(mcnt));
      chk("qr", 32'(QR), 32'(mcnt != DEPTH));
      chk("wv", 32'(WV), 32'(mcnt != 0));
      if (!WV) chk("w_idle", 32'(W), 32'h0);
      if (prev_stall) chk("w_stall_hold", 32'(W), 32'(prev_w));
`ifdef QTW_PARITY_EN
      chk("wp_odd", 32'(^{W, WP}), 32'h1);
`endif
      popw = 0;
      if (WV && WR) begin
        if (expq.size() == 0) chk("byte_underflow", 32'(W), 32'hFFFF_FFFF);
        else begin
          e = expq.pop_front();
          chk("byte", 32'(W), 32'(e));
        end
        if (phase) popw = 1;
        phase = ~phase;
      end
      acc = QV && (mcnt != DEPTH);
      mcnt = mcnt + int'(acc) - int'(popw);
      prev_stall = WV && !WR;
      prev_w = W;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESETN = 1'b0; Q = 16'h0; QV = 1'b0; WR = 1'b0;
    #12;
    chk("rst_wv", 32'(WV), 32'h0);
    chk("rst_w", 32'(W), 32'h0);
    chk("rst_count", 32'(COUNT), 32'h0);
    chk("rst_qr", 32'(QR), 32'h1);
`ifdef QTW_PARITY_EN
    chk("rst_wp", 32'(WP), 32'h1);
`endif
    @(posedge CLK); #1 RESETN = 1'b1;

    // Single word, sink always ready.
    cyc(1'b1, 16'hA55A, 1'b1);
    chk("a55a_hi", 32'({WV, W}), 32'h1A5);
    chk("a55a_cnt1", 32'(COUNT), 32'h1);
    cyc(1'b0, 16'h0, 1'b1);
    chk("a55a_lo", 32'({WV, W}), 32'h15A);
    cyc(1'b0, 16'h0, 1'b1);
    chk("a55a_done", 32'({WV, COUNT}), 32'h0);

    // Fill to full with sink stalled; a fifth word must be refused.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0);
    chk("full_cnt", 32'(COUNT), 32'h4);
    chk("full_qr", 32'(QR), 32'h0);
    cyc(1'b1, 16'h0005, 1'b0);
    chk("full_refuse", 32'(COUNT), 32'h4);
    idle(8, 1'b1);

    // Stall while on the low byte.
    cyc(1'b1, 16'hBEEF, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);
    chk("beef_lo_hold", 32'(W), 32'hEF);
    cyc(1'b0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    chk("beef_popped", 32'(COUNT), 32'h0);

    // Push and pop on the same edge while in LO with two words held.
    cyc(1'b1, 16'h1122, 1'b0);
    cyc(1'b1, 16'h3344, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b1, 16'h5566, 1'b1);
    chk("pushpop_cnt", 32'(COUNT), 32'h2);
    chk("pushpop_hi", 32'({WV, W}), 32'h133);
    idle(6, 1'b1);

    // Parity-relevant bytes 07 / 03 and plain traffic.
    cyc(1'b1, 16'h0703, 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset mid-transfer with three words held.
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    #2 RESETN = 1'b0;
    expq.delete();
    #1;
    chk("arst_wv", 32'(WV), 32'h0);
    chk("arst_count", 32'(COUNT), 32'h0);
    chk("arst_qr", 32'(QR), 32'h1);
    chk("arst_w", 32'(W), 32'h0);
    @(posedge CLK); #1 RESETN = 1'b1;
    cyc(1'b1, 16'h1234, 1'b1);
    chk("post_rst_hi", 32'(W), 32'h12);
    cyc(1'b0, 16'h0, 1'b1);
    chk("post_rst_lo", 32'(W), 32'h34);
    idle(2, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));

    // Drain with a bounded budget.
    for (int i = 0; i < 40 && expq.size() != 0; i++) cyc(1'b0, 16'h0, 1'b1);
    chk("drained", 32'(expq.size()), 32'h0);
    chk("final_count", 32'(COUNT), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/q_to_w_serializer.md
Q_TO_W_SERIALIZER -- requirements
Module: q_to_w_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO depth in 16-bit words; a power of two, 2 to 16.
REQ-002 SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port RESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port Q, input, 16 bits: word from the upstream stage.
REQ-005 SHALL have port QV, input, 1 bit: Q valid.
REQ-006 SHALL have port QR, output, 1 bit: ready to accept Q.
REQ-007 SHALL have port W, output, 8 bits: byte to the downstream stage.
REQ-008 SHALL have port WV, output, 1 bit: W valid.
REQ-009 SHALL have port WR, input, 1 bit: downstream ready.
REQ-010 SHALL have port COUNT, output, $clog2(DEPTH)+1 bits: number of words held.
REQ-011 SHALL have port WP, output, 1 bit, present only under PARITY_EN: odd parity over W.

Function
REQ-012 A word SHALL be accepted on a CLK edge where QV=1 and QR=1, and written at the write pointer.
REQ-013 QR SHALL equal (COUNT != DEPTH), decoded from registered state only.
REQ-014 A word SHALL be popped only after both of its bytes transfer; while full, pushing in the same cycle as a pop is not allowed because QR=0 (no bypass).
REQ-015 Read and write pointers SHALL wrap modulo DEPTH.
REQ-016 On a cycle with a push and no pop, COUNT SHALL increase by 1; with a pop and no push, it SHALL decrease by 1; with both, it SHALL stay unchanged.
REQ-017 The output FSM SHALL have three states: EMPTY, HI and LO.
REQ-018 FSM transitions SHALL be:
- EMPTY to HI when COUNT becomes non-zero.
- HI to LO on a byte transfer (WV=1 and WR=1).
- LO to HI on a byte transfer if words remain after the pop.
- LO to EMPTY on a byte transfer if none remain.
REQ-019 In state HI, W SHALL be head[15:8]; in state LO, W SHALL be head[7:0]; in state EMPTY, W SHALL be 8'h00 and WV SHALL be 0.
REQ-020 WV SHALL be 1 in states HI and LO.
REQ-021 W and WV SHALL be driven from registers; the first byte of a word pushed at edge N into an empty FIFO SHALL appear after edge N (latency 1, no fall-through).
REQ-022 While WV=1 and WR=0, W SHALL hold stable.
REQ-023 Q SHALL be ignored whenever it is not accepted.

Reset
REQ-024 Asserting RESETN low SHALL immediately, without waiting for CLK, set: pointers=0, COUNT=0, state=EMPTY, WV=0, W=8'h00, QR=1, and WP=1 when present.
REQ-025 Storage array contents SHALL NOT be cleared by reset; no output SHALL expose them while COUNT=0.
REQ-026 Reset asserted mid-transfer SHALL discard all held words, including any partially sent word.

Configuration
REQ-027 Macro QTW_PARITY_EN:
- Defined: port WP exists and is registered with W; XOR of W and WP equals 1; WP=1 when W=8'h00.
- Undefined: WP and its logic are absent; all other behaviour is identical.

Verification
REQ-028 Reset, WR=1, push 16'hA55A -> next cycle W=8'hA5 with WV=1, then W=8'h5A, then WV=0; COUNT goes 0 -> 1 -> 0.
REQ-029 WR=0, push 16'h0001 to 16'h0004 -> COUNT=4 and QR=0; a 5th word held on QV is not accepted; after WR=1 the output bytes are 00,01,00,02,00,03,00,04.
REQ-030 Push 16'hBEEF and toggle WR 1,0,0,1 -> W=8'hBE, then stays 8'hEF through the stalled cycles, then pops; no byte is duplicated or lost.
REQ-031 COUNT=2, in state LO: push and transfer on the same edge -> COUNT stays 2 and the FSM goes to HI with the next head word.
REQ-032 COUNT=3, drop RESETN between clock edges -> WV=0, COUNT=0 and QR=1 before the next CLK edge; after release, a new push 16'h1234 yields bytes 12, 34.
REQ-033 With QTW_PARITY_EN defined: W=8'h07 -> WP=0; W=8'h03 -> WP=1; empty -> WP=1.
